// File: rtl/sram_read_req_fifo_if.sv
// Shared types and the scheduler/SRAM-read-path bundle for the SRAM read request queue.
package sram_read_req_pkg;
    localparam int DRAM_ID_WIDTH = 4;
    localparam int XBAR_W        = 8;

    typedef struct packed {
        logic [XBAR_W-1:0] slot_mask;
        logic [XBAR_W-1:0] shift_mask;
        logic [XBAR_W-1:0] valid_mask;
    } xbar_desc_t;

    typedef struct packed {
        logic       valid;
        logic       row_or_col;
        xbar_desc_t xbar;
    } sram_read_req_t;
endpackage

interface sram_read_req_fifo_if #(
    parameter int DEPTH = 8,
    parameter int ID_W  = sram_read_req_pkg::DRAM_ID_WIDTH
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // push side (scheduler / DRAM request path)
    logic                                sched_write;
    logic                                be_dr_r_req_accepted;
    logic                                row_or_col;
    logic [ID_W-1:0]                     id;
    sram_read_req_pkg::xbar_desc_t       xbar_desc;
    // pop side (SRAM read path) and control
    logic                                be_sram_rd_req_accepted;
    logic                                flush;
    // status / head
    sram_read_req_pkg::sram_read_req_t   sram_read_req;
    logic [ID_W-1:0]                     sram_read_req_id;
    logic                                sram_read_req_latched;
    logic                                sram_read_queue_full;
    logic                                sram_read_queue_afull;
    logic [CNT_W-1:0]                    sram_read_queue_count;

    modport master (
        output sched_write, be_dr_r_req_accepted, row_or_col, id, xbar_desc,
               be_sram_rd_req_accepted, flush,
        input  sram_read_req, sram_read_req_id, sram_read_req_latched,
               sram_read_queue_full, sram_read_queue_afull, sram_read_queue_count
    );

    modport slave (
        input  sched_write, be_dr_r_req_accepted, row_or_col, id, xbar_desc,
               be_sram_rd_req_accepted, flush,
        output sram_read_req, sram_read_req_id, sram_read_req_latched,
               sram_read_queue_full, sram_read_queue_afull, sram_read_queue_count
    );
endinterface

// File: rtl/sram_read_req_fifo.sv
// Circular-buffer queue of scratchpad SRAM read requests. Entries enter when the
// scheduler write and the DRAM read accept coincide; the head feeds the SRAM read path.
module sram_read_req_fifo
    import sram_read_req_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ID_W         = DRAM_ID_WIDTH,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                CLK,
    input  logic                nRST,
    sram_read_req_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            row_or_col;
        logic [ID_W-1:0] id;
        xbar_desc_t      xbar;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             latched;

    logic   full;
    logic   afull;
    logic   valid;
    logic   push;
    logic   pop;
    entry_t head;

    // Status is decoded from the registered count only.
    assign full  = (count == CNT_W'(DEPTH));
    assign afull = (count >= CNT_W'(AFULL_THRESH));
    assign valid = (count != '0);

    // A full queue drops the push; flush wins over both directions.
    assign push = bus.sched_write & bus.be_dr_r_req_accepted & ~full & ~bus.flush;
    assign pop  = bus.be_sram_rd_req_accepted & valid & ~bus.flush;

    // Entry storage; not reset because the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{row_or_col: bus.row_or_col, id: bus.id, xbar: bus.xbar_desc};
        end
    end

    // Pointers, occupancy and the push pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            latched <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            latched <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(push);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            latched <= push;
        end
    end

    // Head presentation; all fields read as zero when the queue is empty.
    always_comb begin
        head              = mem[rd_ptr];
        bus.sram_read_req = '0;
        bus.sram_read_req_id = '0;
        if (valid) begin
            bus.sram_read_req.valid      = 1'b1;
            bus.sram_read_req.row_or_col = head.row_or_col;
            bus.sram_read_req.xbar       = head.xbar;
            bus.sram_read_req_id         = head.id;
        end
    end

    assign bus.sram_read_req_latched = latched;
    assign bus.sram_read_queue_full  = full;
    assign bus.sram_read_queue_afull = afull;
    assign bus.sram_read_queue_count = count;
endmodule

// File: tb/tb_sram_read_req_fifo.sv
// Directed and randomized checks of the SRAM read request queue against a queue model.
module tb_sram_read_req_fifo;
    import sram_read_req_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ID_W   = DRAM_ID_WIDTH;
    localparam int AFULL  = DEPTH - 2;
    localparam int XD_W   = $bits(xbar_desc_t);

    typedef struct {
        logic            roc;
        logic [ID_W-1:0] id;
        xbar_desc_t      xbar;
    } ent_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    sram_read_req_fifo_if #(.DEPTH(DEPTH), .ID_W(ID_W)) bus ();

    sram_read_req_fifo #(.DEPTH(DEPTH), .ID_W(ID_W), .AFULL_THRESH(AFULL)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    ent_t q[$];
    logic exp_latched = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        ent_t h;
        sz = q.size();
        h = '{roc: 1'b0, id: '0, xbar: '0};
        if (sz != 0) h = q[0];
        chk({tag, ".valid"}, 64'(bus.sram_read_req.valid), 64'(sz != 0));
        chk({tag, ".roc"},   64'(bus.sram_read_req.row_or_col), 64'(h.roc));
        chk({tag, ".xbar"},  64'(bus.sram_read_req.xbar), 64'(h.xbar));
        chk({tag, ".id"},    64'(bus.sram_read_req_id), 64'(h.id));
        chk({tag, ".count"}, 64'(bus.sram_read_queue_count), 64'(sz));
        chk({tag, ".full"},  64'(bus.sram_read_queue_full), 64'(sz == DEPTH));
        chk({tag, ".afull"}, 64'(bus.sram_read_queue_afull), 64'(sz >= AFULL));
        chk({tag, ".latched"}, 64'(bus.sram_read_req_latched), 64'(exp_latched));
    endtask

    function automatic xbar_desc_t rnd_xbar();
        logic [31:0] r;
        r = $urandom;
        return r[XD_W-1:0];
    endfunction

    function automatic logic [ID_W-1:0] rnd_id();
        logic [31:0] r;
        r = $urandom;
        return r[ID_W-1:0];
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, check outputs.
    task automatic step(input string tag, input logic sw, input logic acc, input logic roc,
                        input logic [ID_W-1:0] tid, input xbar_desc_t xd,
                        input logic ack, input logic fl);
        logic do_push, do_pop;
        bus.sched_write             = sw;
        bus.be_dr_r_req_accepted    = acc;
        bus.row_or_col              = roc;
        bus.id                      = tid;
        bus.xbar_desc               = xd;
        bus.be_sram_rd_req_accepted = ack;
        bus.flush                   = fl;
        @(posedge CLK);
        do_push = sw && acc && (q.size() < DEPTH) && !fl;
        do_pop  = ack && (q.size() > 0) && !fl;
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{roc: roc, id: tid, xbar: xd});
        end
        exp_latched = do_push;
        #1;
        check_all(tag);
    endtask

    task automatic push_one(input string tag, input logic [ID_W-1:0] tid);
        step(tag, 1'b1, 1'b1, 1'($urandom_range(0, 1)), tid, rnd_xbar(), 1'b0, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        xbar_desc_t x1;
        bus.sched_write = 0; bus.be_dr_r_req_accepted = 0; bus.row_or_col = 0;
        bus.id = '0; bus.xbar_desc = '0; bus.be_sram_rd_req_accepted = 0; bus.flush = 0;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        #3 nRST = 1'b1;
        @(posedge CLK); #1;

        // 1: single push then accept
        x1 = 24'hA5_3C_0F;
        step("t1_push", 1'b1, 1'b1, 1'b1, 4'd3, x1, 1'b0, 1'b0);
        chk("t1_id_direct", 64'(bus.sram_read_req_id), 64'd3);
        chk("t1_xbar_direct", 64'(bus.sram_read_req.xbar), 64'(x1));
        pop_one("t1_pop");
        chk("t1_empty_direct", 64'(bus.sram_read_req.valid), 64'd0);

        // 2: fill, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) push_one("t2_fill", ID_W'(i));
        chk("t2_full_direct", 64'(bus.sram_read_queue_full), 64'd1);
        push_one("t2_drop", 4'hF);
        chk("t2_count_direct", 64'(bus.sram_read_queue_count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", 64'(bus.sram_read_req_id), 64'(i));
            pop_one("t2_drain");
        end

        // full with simultaneous pop and push: only the pop happens
        for (int i = 0; i < DEPTH; i++) push_one("t2b_fill", rnd_id());
        step("t2b_full_pp", 1'b1, 1'b1, 1'b0, rnd_id(), rnd_xbar(), 1'b1, 1'b0);
        chk("t2b_count_direct", 64'(bus.sram_read_queue_count), 64'(DEPTH - 1));
        step("t2b_flush", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

        // 3: steady push+pop at count 4, pointers wrap
        for (int i = 0; i < 4; i++) push_one("t3_fill", rnd_id());
        for (int i = 0; i < 20; i++)
            step("t3_pp", 1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd_id(), rnd_xbar(), 1'b1, 1'b0);
        chk("t3_count_direct", 64'(bus.sram_read_queue_count), 64'd4);

        // 4: write without DRAM accept is not a push
        step("t4_noacc", 1'b1, 1'b0, 1'b1, rnd_id(), rnd_xbar(), 1'b0, 1'b0);
        chk("t4_latched_direct", 64'(bus.sram_read_req_latched), 64'd0);

        // 5: flush overrides push+pop at count 5
        push_one("t5_fill", rnd_id());
        step("t5_flush", 1'b1, 1'b1, 1'b1, rnd_id(), rnd_xbar(), 1'b1, 1'b1);
        chk("t5_count_direct", 64'(bus.sram_read_queue_count), 64'd0);

        // 6: asynchronous reset mid-stream at count 3
        for (int i = 0; i < 3; i++) push_one("t6_fill", rnd_id());
        #2 nRST = 1'b0;
        #1;
        q.delete();
        exp_latched = 1'b0;
        check_all("t6_reset");
        bus.sched_write = 1'b0;
        #2 nRST = 1'b1;
        @(posedge CLK); #1;
        push_one("t6_push", 4'd9);
        chk("t6_id_direct", 64'(bus.sram_read_req_id), 64'd9);

        // randomized traffic
        for (int i = 0; i < 500; i++)
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), rnd_id(), rnd_xbar(),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
